fir_out_decim_sink: RTL and testbench

- Consumer end of the FIR output stream.
- Takes the 20-bit signed filter output every enabled cycle and decimates by DECIM.
- Requantises to OUT_W bits with round-half-up and saturation, then buffers in a small FIFO.
- Presents samples to the downstream core over a valid/ready handshake, with sticky overflow and saturation flags for firmware.

---
 rtl/fir_pkg.sv | 12 +
 rtl/fir_out_decim_sink_if.sv | 25 ++
 rtl/fir_sync_fifo.sv | 77 +++++++
 rtl/fir_out_decim_sink.sv | 120 ++++++++++++
 tb/tb_fir_out_decim_sink.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared FIR constants used by the filter datapath and its output sink.
package fir_pkg;

    localparam int FIR_IN_W  = 15;
    localparam int FIR_ACC_W = 20;
    localparam int FIR_TAPS  = 37;
    localparam int FIR_OUT_W = 16;
    localparam int FIR_SHIFT = 4;
    localparam int FIR_DECIM = 2;
    localparam int FIR_DEPTH = 8;

endpackage

// File: rtl/fir_out_decim_sink_if.sv
// Stream bundle for the FIR output sink: input samples in, decimated samples out.
interface fir_out_decim_sink_if
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_ACC_W,
    parameter int OUT_W = FIR_OUT_W
);

    logic                    in_en;
    logic signed [IN_W-1:0]  in_data;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_en, in_data, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  in_en, in_data, out_ready,
        output out_data, out_valid
    );

endinterface

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO with registered level; clear takes priority over push/pop.
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == LVL_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPop   = pop_i & ~empty_o & ~clr_i;
    assign doPush  = push_i & (~full_o | doPop) & ~clr_i;
    assign rdata_o = mem_q[rdPtr_q];
    assign level_o = count_q;

    // Next pointer and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clr_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + 1'b1;
            if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
            case ({doPush, doPop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is reset so the head never reads X even before the first write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fir_out_decim_sink.sv
// FIR output sink: decimate, requantise with round-half-up and saturation, buffer, hand off.
module fir_out_decim_sink
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_ACC_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = FIR_SHIFT,
    parameter int DECIM = FIR_DECIM,
    parameter int DEPTH = FIR_DEPTH,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  flags_clr,
    fir_out_decim_sink_if.slave   bus,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  ovf_flag,
    output logic                  sat_flag
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [IN_W:0] RND     = (IN_W + 1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_W:0] SAT_MAX = (IN_W + 1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = (IN_W + 1)'(-(2 ** (OUT_W - 1)));

    logic [PH_W-1:0]         phase_q, phase_d;
    logic                    keep;
    logic signed [IN_W:0]    rounded;
    logic signed [IN_W:0]    shifted;
    logic                    satHi;
    logic                    satLo;
    logic signed [OUT_W-1:0] reqData;
    logic                    s1Valid_q, s1Valid_d;
    logic signed [OUT_W-1:0] s1Data_q, s1Data_d;
    logic                    sat_q, sat_d;
    logic                    ovf_q, ovf_d;
    logic                    satEvent;
    logic                    ovfEvent;
    logic                    popReq;
    logic                    fifoFull;
    logic                    fifoEmpty;
    logic [OUT_W-1:0]        fifoRdata;

    // One extra bit of headroom keeps the rounding add from wrapping at full scale.
    assign keep    = bus.in_en & (phase_q == '0) & ~clr;
    assign rounded = $signed({bus.in_data[IN_W-1], bus.in_data}) + RND;
    assign shifted = rounded >>> SHIFT;
    assign satHi   = (shifted > SAT_MAX);
    assign satLo   = (shifted < SAT_MIN);

    // Clamp the rounded value into the output range.
    always_comb begin
        reqData = shifted[OUT_W-1:0];
        if (satHi)      reqData = SAT_MAX[OUT_W-1:0];
        else if (satLo) reqData = SAT_MIN[OUT_W-1:0];
    end

    // Phase only moves on enabled cycles so idle gaps do not shift the decimation grid.
    always_comb begin
        phase_d = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (bus.in_en) begin
            phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
        end
    end

    assign popReq   = bus.out_ready & ~fifoEmpty;
    assign satEvent = keep & (satHi | satLo);
    assign ovfEvent = s1Valid_q & fifoFull & ~popReq & ~clr;

    // Stage-1 load and sticky flag update; a new event beats a coincident flags_clr.
    always_comb begin
        s1Valid_d = keep;
        s1Data_d  = keep ? reqData : s1Data_q;
        sat_d     = satEvent | (sat_q & ~flags_clr);
        ovf_d     = ovfEvent | (ovf_q & ~flags_clr);
    end

    // Decimation phase, stage-1 requant register and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= '0;
            s1Valid_q <= 1'b0;
            s1Data_q  <= '0;
            sat_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            s1Valid_q <= s1Valid_d;
            s1Data_q  <= s1Data_d;
            sat_q     <= sat_d;
            ovf_q     <= ovf_d;
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .push_i  (s1Valid_q),
        .pop_i   (bus.out_ready),
        .wdata_i (s1Data_q),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifo_level)
    );

    assign bus.out_data  = fifoRdata;
    assign bus.out_valid = ~fifoEmpty;
    assign sat_flag      = sat_q;
    assign ovf_flag      = ovf_q;

endmodule

// File: tb/tb_fir_out_decim_sink.sv
// Bench for fir_out_decim_sink: directed scenarios plus randomized traffic against a queue model.
module tb_fir_out_decim_sink;
    import fir_pkg::*;

    localparam int IN_W  = FIR_ACC_W;
    localparam int OUT_W = FIR_OUT_W;
    localparam int SHIFT = FIR_SHIFT;
    localparam int DECIM = 2;
    localparam int DEPTH = 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int SMAX  = (1 << (OUT_W - 1)) - 1;
    localparam int SMIN  = -(1 << (OUT_W - 1));

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic clr       = 1'b0;
    logic flags_clr = 1'b0;
    logic [LVL_W-1:0] fifo_level, fifo_level3;
    logic ovf_flag, sat_flag, ovf_flag3, sat_flag3;

    fir_out_decim_sink_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
    fir_out_decim_sink_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus3 ();

    fir_out_decim_sink #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(DECIM), .DEPTH(DEPTH), .LVL_W(LVL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .flags_clr(flags_clr), .bus(bus),
        .fifo_level(fifo_level), .ovf_flag(ovf_flag), .sat_flag(sat_flag)
    );

    fir_out_decim_sink #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(3), .DEPTH(DEPTH), .LVL_W(LVL_W)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .flags_clr(flags_clr), .bus(bus3),
        .fifo_level(fifo_level3), .ovf_flag(ovf_flag3), .sat_flag(sat_flag3)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    int mq[$];
    bit mPendV;
    int mPendD;
    int mPhase;
    bit mSat;
    bit mOvf;

    function automatic int requant(input int x, output bit sat);
        int r;
        r   = (x + (1 << (SHIFT - 1))) >>> SHIFT;
        sat = 1'b0;
        if (r > SMAX) begin
            r   = SMAX;
            sat = 1'b1;
        end else if (r < SMIN) begin
            r   = SMIN;
            sat = 1'b1;
        end
        return r;
    endfunction

    function automatic void modelReset();
        mq.delete();
        mPendV = 1'b0;
        mPendD = 0;
        mPhase = 0;
        mSat   = 1'b0;
        mOvf   = 1'b0;
    endfunction

    function automatic void modelEdge(input bit en, input int x, input bit ready, input bit c, input bit fc);
        bit popNow, satEv, ovfEv, s;
        int r;
        satEv = 1'b0;
        ovfEv = 1'b0;
        if (c) begin
            mq.delete();
            mPendV = 1'b0;
            mPhase = 0;
        end else begin
            popNow = ready && (mq.size() > 0);
            if (mPendV) begin
                if (mq.size() < DEPTH || popNow) mq.push_back(mPendD);
                else ovfEv = 1'b1;
            end
            if (popNow) void'(mq.pop_front());
            mPendV = 1'b0;
            if (en) begin
                if (mPhase == 0) begin
                    r      = requant(x, s);
                    mPendV = 1'b1;
                    mPendD = r;
                    satEv  = s;
                end
                mPhase = (mPhase + 1) % DECIM;
            end
        end
        mSat = satEv || (mSat && !fc);
        mOvf = ovfEv || (mOvf && !fc);
    endfunction

    task automatic applyStimulus(input bit en, input int x, input bit ready,
                                 input bit c = 1'b0, input bit fc = 1'b0);
        bus.in_en     = en;
        bus.in_data   = IN_W'(x);
        bus.out_ready = ready;
        clr           = c;
        flags_clr     = fc;
        @(posedge clk);
        modelEdge(en, x, ready, c, fc);
        @(negedge clk);
        bus.in_en     = 1'b0;
        bus.out_ready = 1'b0;
        clr           = 1'b0;
        flags_clr     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        testsRun++;
        if ({fifo_level, bus.out_valid, bus.out_data, ovf_flag, sat_flag} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got lvl=%0d v=%b d=%h ovf=%b sat=%b, want all 0",
                     fifo_level, bus.out_valid, bus.out_data, ovf_flag, sat_flag);
        end
        rst_n = 1'b1;
        @(negedge clk);
        testsRun++;
        if ({fifo_level, bus.out_valid, fifo_level3, bus3.out_valid} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: got lvl=%0d v=%b lvl3=%0d v3=%b, want 0",
                     fifo_level, bus.out_valid, fifo_level3, bus3.out_valid);
        end
    endtask

    task automatic test_basic();
        applyStimulus(1'b1, 24, 1'b0);
        testsRun++;
        if (bus.out_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL basic_valid_early: got %b want 0", bus.out_valid);
        end
        applyStimulus(1'b1, 100, 1'b0);
        testsRun++;
        if (bus.out_valid !== 1'b1 || fifo_level !== LVL_W'(1)) begin
            testsFailed++;
            $display("[TB] FAIL basic_valid_rise: got v=%b lvl=%0d want v=1 lvl=1", bus.out_valid, fifo_level);
        end
        applyStimulus(1'b1, -24, 1'b0);
        applyStimulus(1'b1, 5, 1'b0);
        testsRun++;
        if (fifo_level !== LVL_W'(2) || bus.out_data !== OUT_W'(2)) begin
            testsFailed++;
            $display("[TB] FAIL basic_level_head: got lvl=%0d d=%0d want lvl=2 d=2", fifo_level, bus.out_data);
        end
        applyStimulus(1'b0, 0, 1'b1);
        testsRun++;
        if (bus.out_data !== OUT_W'(-1)) begin
            testsFailed++;
            $display("[TB] FAIL basic_second: got %0d want -1", bus.out_data);
        end
        applyStimulus(1'b0, 0, 1'b1);
        testsRun++;
        if (bus.out_valid !== 1'b0 || fifo_level !== '0) begin
            testsFailed++;
            $display("[TB] FAIL basic_drained: got v=%b lvl=%0d want 0", bus.out_valid, fifo_level);
        end
    endtask

    task automatic test_saturation();
        int satExp[3];
        satExp = '{SMAX, SMIN, 0};
        applyStimulus(1'b1, 524287, 1'b0);
        testsRun++;
        if (sat_flag !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sat_set: got %b want 1", sat_flag);
        end
        applyStimulus(1'b1, 0, 1'b0);
        applyStimulus(1'b1, -524288, 1'b0);
        applyStimulus(1'b1, 0, 1'b0);
        applyStimulus(1'b1, -8, 1'b0);
        applyStimulus(1'b1, 0, 1'b0);
        testsRun++;
        if (fifo_level !== LVL_W'(3)) begin
            testsFailed++;
            $display("[TB] FAIL sat_level: got %0d want 3", fifo_level);
        end
        for (int i = 0; i < 3; i++) begin
            testsRun++;
            if (bus.out_data !== OUT_W'(satExp[i])) begin
                testsFailed++;
                $display("[TB] FAIL sat_drain%0d: got %0d want %0d", i, bus.out_data, satExp[i]);
            end
            applyStimulus(1'b0, 0, 1'b1);
        end
        testsRun++;
        if (sat_flag !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sat_sticky: got %b want 1", sat_flag);
        end
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
        testsRun++;
        if (sat_flag !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sat_clear: got %b want 0", sat_flag);
        end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 16 * k, 1'b0);
            applyStimulus(1'b1, 0, 1'b0);
        end
        applyStimulus(1'b0, 0, 1'b0);
        testsRun++;
        if (fifo_level !== LVL_W'(DEPTH) || ovf_flag !== 1'b1 || bus.out_data !== OUT_W'(1)) begin
            testsFailed++;
            $display("[TB] FAIL ovf_full: got lvl=%0d ovf=%b d=%0d want lvl=8 ovf=1 d=1",
                     fifo_level, ovf_flag, bus.out_data);
        end
    endtask

    task automatic test_back_to_back();
        int want;
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
        testsRun++;
        if (ovf_flag !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_flagclr: got %b want 0", ovf_flag);
        end
        applyStimulus(1'b1, 16 * 11, 1'b0);
        applyStimulus(1'b1, 0, 1'b1);
        testsRun++;
        if (fifo_level !== LVL_W'(DEPTH) || ovf_flag !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_pushpop: got lvl=%0d ovf=%b want lvl=8 ovf=0", fifo_level, ovf_flag);
        end
        for (int i = 0; i < DEPTH; i++) begin
            want = (i < DEPTH - 1) ? i + 2 : 11;
            testsRun++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== OUT_W'(want)) begin
                testsFailed++;
                $display("[TB] FAIL b2b_drain%0d: got v=%b d=%0d want v=1 d=%0d", i, bus.out_valid, bus.out_data, want);
            end
            applyStimulus(1'b0, 0, 1'b1);
        end
        testsRun++;
        if (fifo_level !== '0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_empty: got %0d want 0", fifo_level);
        end
    endtask

    task automatic test_decim3();
        for (int i = 0; i < 9; i++) begin
            bus3.in_en   = (i % 2 == 0);
            bus3.in_data = IN_W'(16 * (i / 2 + 1));
            @(posedge clk);
            @(negedge clk);
        end
        bus3.in_en = 1'b0;
        testsRun++;
        if (fifo_level3 !== LVL_W'(2) || bus3.out_data !== OUT_W'(1) || {ovf_flag3, sat_flag3} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL decim3_kept: got lvl=%0d d=%0d flags=%b%b want lvl=2 d=1 flags=00",
                     fifo_level3, bus3.out_data, ovf_flag3, sat_flag3);
        end
        bus3.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.out_ready = 1'b0;
        testsRun++;
        if (fifo_level3 !== LVL_W'(1) || bus3.out_data !== OUT_W'(4)) begin
            testsFailed++;
            $display("[TB] FAIL decim3_fourth: got lvl=%0d d=%0d want lvl=1 d=4", fifo_level3, bus3.out_data);
        end
    endtask

    task automatic test_random();
        logic signed [IN_W-1:0] raw;
        int x;
        bit en, ready, fc;
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: x = 524270 + int'($urandom_range(0, 17));
                1: x = -524288 + int'($urandom_range(0, 17));
                2: x = int'($urandom_range(0, 4000)) - 2000;
                default: begin
                    raw = IN_W'($urandom);
                    x   = int'(raw);
                end
            endcase
            en    = ($urandom_range(0, 3) != 0);
            ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            fc    = ($urandom_range(0, 15) == 0);
            applyStimulus(en, x, ready, 1'b0, fc);
            testsRun++;
            if (fifo_level !== LVL_W'(mq.size()) || bus.out_valid !== (mq.size() > 0) ||
                sat_flag !== mSat || ovf_flag !== mOvf) begin
                testsFailed++;
                $display("[TB] FAIL rand_state@%0d: got lvl=%0d v=%b sat=%b ovf=%b want lvl=%0d sat=%b ovf=%b",
                         i, fifo_level, bus.out_valid, sat_flag, ovf_flag, mq.size(), mSat, mOvf);
            end
            if (mq.size() > 0) begin
                testsRun++;
                if (bus.out_data !== OUT_W'(mq[0])) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_data@%0d: got %0d want %0d", i, bus.out_data, mq[0]);
                end
            end
        end
    endtask

    task automatic test_clr();
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 524287, 1'b0);
        applyStimulus(1'b1, 0, 1'b0);
        applyStimulus(1'b1, 32, 1'b0);
        applyStimulus(1'b1, 0, 1'b0);
        applyStimulus(1'b1, 48, 1'b0);
        applyStimulus(1'b1, 0, 1'b0);
        applyStimulus(1'b1, 64, 1'b0);
        testsRun++;
        if (fifo_level !== LVL_W'(3)) begin
            testsFailed++;
            $display("[TB] FAIL clr_prefill: got %0d want 3", fifo_level);
        end
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
        testsRun++;
        if (fifo_level !== '0 || bus.out_valid !== 1'b0 || sat_flag !== 1'b1 || ovf_flag !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clr_effect: got lvl=%0d v=%b sat=%b ovf=%b want lvl=0 v=0 sat=1 ovf=0",
                     fifo_level, bus.out_valid, sat_flag, ovf_flag);
        end
        applyStimulus(1'b0, 0, 1'b0);
        testsRun++;
        if (fifo_level !== '0) begin
            testsFailed++;
            $display("[TB] FAIL clr_inflight_lost: got %0d want 0", fifo_level);
        end
        applyStimulus(1'b1, 80, 1'b0);
        applyStimulus(1'b0, 0, 1'b0);
        testsRun++;
        if (fifo_level !== LVL_W'(1) || bus.out_data !== OUT_W'(5)) begin
            testsFailed++;
            $display("[TB] FAIL clr_next_first: got lvl=%0d d=%0d want lvl=1 d=5", fifo_level, bus.out_data);
        end
    endtask

    task automatic test_reset_mid();
        applyStimulus(1'b1, 96, 1'b0);
        rst_n = 1'b0;
        #1;
        testsRun++;
        if ({fifo_level, bus.out_valid, bus.out_data, ovf_flag, sat_flag, fifo_level3, bus3.out_valid} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid: got lvl=%0d v=%b d=%h ovf=%b sat=%b lvl3=%0d, want all 0",
                     fifo_level, bus.out_valid, bus.out_data, ovf_flag, sat_flag, fifo_level3);
        end
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        testsRun++;
        if (fifo_level !== '0 || sat_flag !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_release: got lvl=%0d sat=%b want 0", fifo_level, sat_flag);
        end
    endtask

    initial begin
        bus.in_en      = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus3.in_en     = 1'b0;
        bus3.in_data   = '0;
        bus3.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_overflow();
        test_back_to_back();
        test_decim3();
        test_random();
        test_clr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
